add_controller: RTL and testbench
=================================

// Module: add_controller
// PURPOSE
//  Control FSM for the 6-bit add datapath (regs xi/yi, muxes sa/sb/sy, one adder).
//  Generates the enx/eny/sa/sb/sy control word each cycle so that the datapath computes
//  result = (a+b) + n*(a+3) + 3 (mod 64) for a run-time iteration count n.
//  Sits beside the datapath and shares its clock. Datapath a/b must stay stable while busy.
//  Start/busy/done handshake to the surrounding logic.
// PARAMETERS
//  CW       4    width of iteration count input/counter
// PORTS
//  CLK      in   1    clock, all state updates on posedge
//  RST      in   1    synchronous, active-high reset
//  start    in   1    request a run; sampled only in IDLE
//  n_iter   in   CW   accumulate iterations, latched when start accepted
//  enx      out  1    datapath xi load enable
//  eny      out  1    datapath yi load enable
//  sa       out  1    adder A mux: 1=a, 0=xi
//  sb       out  1    adder B mux: 1=b, else see sy
//  sy       out  1    adder B mux when sb=0: 1=yi, 0=constant 3
//  busy     out  1    high from accept cycle+1 until the done cycle inclusive
//  done     out  1    high while datapath result port holds the final value
// BEHAVIOUR
//  - States: IDLE, LD_X, LD_Y, ACC, OUT. State and counter are registered. Control outputs
//    are decoded from the state only (Moore).
//  - Reset (RST=1 at posedge): state<=IDLE, cnt<=0. All outputs are 0 from the next cycle.
//    RST takes priority in every state, including mid-run. A reset mid-run abandons the run.
//  - IDLE: all outputs 0. If start=1, go to LD_X and latch cnt<=n_iter. Otherwise stay.
//  - LD_X: sa=1, sb=1, enx=1 -> xi<=a+b. Go to LD_Y.
//  - LD_Y: sa=1, sb=0, sy=0, eny=1 -> yi<=a+3. Go to ACC if cnt!=0, else OUT.
//  - ACC: sa=0, sb=0, sy=1, enx=1 -> xi<=xi+yi. cnt<=cnt-1.
//    Go to OUT when cnt==1, else stay in ACC. ACC lasts exactly n_iter cycles.
//  - OUT: sa=0, sb=0, sy=0, enx=0, eny=0 -> datapath result=xi+3. done=1.
//    Go to IDLE next cycle.
//  - enx and eny are never high together. In states other than IDLE, busy=1.
//  - Latency: start accepted at edge t. done is high in cycle t+3+n_iter
//    (counted in cycles after edge t).
//  - start while busy is ignored. If start=1 in the OUT cycle, it is not accepted there;
//    if start is still 1 in the following IDLE cycle, it is accepted then (back-to-back runs,
//    1 idle cycle between runs).
//  - Arithmetic is done in the datapath and is 6-bit mod 64; the controller never inspects
//    data. n_iter=0 skips ACC entirely.
//  - n_iter changes after acceptance have no effect on the current run.
// CONFIGURATION
//  - DONE_ACK_EN defined: adds input port done_ack (1 bit). OUT is held, with its control
//    word, done=1 and busy=1, until done_ack=1 is sampled. The FSM then goes to IDLE on
//    that edge. done_ack=1 in the first OUT cycle gives the same timing as the undefined
//    case. done_ack is ignored in every state except OUT.
//  - DONE_ACK_EN undefined: no done_ack port. OUT lasts exactly one cycle (done is a
//    1-cycle pulse).
// TESTING
//  1 Reset: RST=1 for 2 cycles with start=1 -> state IDLE; enx=eny=sa=sb=sy=busy=done=0.
//  2 Basic: a=5, b=7, n_iter=0, start pulse -> LD_X, LD_Y, OUT sequence.
//    done at t+3; result=15.
//  3 Loop: a=5, b=7, n_iter=2 -> 2 ACC cycles with enx=1, sy=1.
//    done at t+5; result=12+2*8+3=31.
//  4 Wrap: a=60, b=10, n_iter=1 -> xi=6, yi=63, xi=5; result=8 (mod 64). done at t+4.
//  5 Handshake: start held high continuously with n_iter=1 -> runs back-to-back;
//    done pulses 5 cycles apart (4 busy + 1 IDLE). start asserted mid-run does not
//    restart the run.
//  6 Mid-run reset: RST=1 in the 2nd ACC cycle of n_iter=5 -> IDLE next cycle,
//    all outputs 0, no done. With DONE_ACK_EN: done_ack held 0 for 3 cycles -> done
//    stays 1, then done_ack=1 -> IDLE next cycle.

Source files
------------

// File: rtl/add_controller.sv
// Moore control FSM for the 6-bit add datapath: sequences xi/yi loads so result = (a+b) + n*(a+3) + 3.
// Optional `DONE_ACK_EN adds a done_ack input that holds OUT until the result is acknowledged.
module add_controller #(
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [CW-1:0] n_iter,
`ifdef DONE_ACK_EN
  input  logic          done_ack,
`endif
  output logic          enx,
  output logic          eny,
  output logic          sa,
  output logic          sb,
  output logic          sy,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_X = 3'd1,
    LD_Y = 3'd2,
    ACC  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Release condition for OUT; without the handshake OUT is a single-cycle pulse.
  logic out_release;
`ifdef DONE_ACK_EN
  assign out_release = done_ack;
`else
  assign out_release = 1'b1;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_nx = state;
    cnt_nx   = cnt;
    enx      = 1'b0;
    eny      = 1'b0;
    sa       = 1'b0;
    sb       = 1'b0;
    sy       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = LD_X;
          cnt_nx   = n_iter;
        end
      end

      LD_X: begin
        sa       = 1'b1;
        sb       = 1'b1;
        enx      = 1'b1;
        busy     = 1'b1;
        state_nx = LD_Y;
      end

      LD_Y: begin
        sa       = 1'b1;
        eny      = 1'b1;
        busy     = 1'b1;
        state_nx = (cnt != '0) ? ACC : OUT;
      end

      ACC: begin
        sy     = 1'b1;
        enx    = 1'b1;
        busy   = 1'b1;
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = OUT;
      end

      OUT: begin
        busy = 1'b1;
        done = 1'b1;
        if (out_release) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_add_controller.sv
// Directed bench for add_controller with a behavioural model of the 6-bit datapath it drives.
// Inputs change just after negedge; outputs are checked at the following negedge.
module tb_add_controller;

  localparam int CW = 4;

  // Control word packing: {enx, eny, sa, sb, sy, busy, done}
  localparam logic [6:0] W_IDLE = 7'b000_0000;
  localparam logic [6:0] W_LDX  = 7'b101_1010;
  localparam logic [6:0] W_LDY  = 7'b011_0010;
  localparam logic [6:0] W_ACC  = 7'b100_0110;
  localparam logic [6:0] W_OUT  = 7'b000_0011;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b1;
  logic [CW-1:0] n_iter = '0;
`ifdef DONE_ACK_EN
  logic          done_ack = 1'b1;
`endif
  logic enx, eny, sa, sb, sy, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  add_controller #(.CW(CW)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .n_iter (n_iter),
`ifdef DONE_ACK_EN
    .done_ack (done_ack),
`endif
    .enx    (enx),
    .eny    (eny),
    .sa     (sa),
    .sb     (sb),
    .sy     (sy),
    .busy   (busy),
    .done   (done)
  );

  // Datapath driven by the controller outputs
  logic [5:0] a = '0, b = '0, xi = '0, yi = '0;
  logic [5:0] op_a, op_b, sum;
  logic [6:0] ctl;
  assign op_a = sa ? a : xi;
  assign op_b = sb ? b : (sy ? yi : 6'd3);
  assign sum  = op_a + op_b;
  assign ctl  = {enx, eny, sa, sb, sy, busy, done};

  always @(posedge CLK) begin
    if (enx) xi <= sum;
    if (eny) yi <= sum;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] exp_ctl);
    @(negedge CLK);
    check(tag, 32'(ctl), 32'(exp_ctl));
  endtask

  // One run with start pulsed for the accept cycle; n_iter is scrambled after acceptance.
  task automatic run(input string tag, input logic [5:0] av, input logic [5:0] bv,
                     input logic [CW-1:0] n, input logic [5:0] exp_res);
    a = av; b = bv; n_iter = n; start = 1'b1;
    step({tag, "_ldx"}, W_LDX);
    start  = 1'b0;
    n_iter = ~n;
    step({tag, "_ldy"}, W_LDY);
    for (int i = 0; i < int'(n); i++) step({tag, "_acc"}, W_ACC);
    step({tag, "_out"}, W_OUT);
    check({tag, "_result"}, 32'(sum), 32'(exp_res));
    step({tag, "_idle"}, W_IDLE);
  endtask

  initial begin
    int done_seen;
    logic [6:0] seq5 [10];

    // 1: reset held 2 cycles with start high
    step("rst_c1", W_IDLE);
    step("rst_c2", W_IDLE);
    RST = 1'b0; start = 1'b0;
    step("rst_idle", W_IDLE);

    // 2-4: basic, loop, wrap
    run("basic", 6'd5, 6'd7, 4'd0, 6'd15);
    run("loop",  6'd5, 6'd7, 4'd2, 6'd31);
    run("wrap",  6'd60, 6'd10, 4'd1, 6'd8);

    // 5: start held high -> back-to-back runs, one idle cycle between
    seq5 = '{W_LDX, W_LDY, W_ACC, W_OUT, W_IDLE, W_LDX, W_LDY, W_ACC, W_OUT, W_IDLE};
    a = 6'd1; b = 6'd2; n_iter = 4'd1; start = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step("b2b_seq", seq5[i]);
      if (done) begin
        done_seen++;
        check("b2b_result", 32'(sum), 32'd10);
      end
      if (i == 9) start = 1'b0;
    end
    check("b2b_done_count", 32'(done_seen), 32'd2);
    step("b2b_idle", W_IDLE);

    // 6: reset in the 2nd ACC cycle of an n_iter=5 run
    a = 6'd3; b = 6'd4; n_iter = 4'd5; start = 1'b1;
    step("mrst_ldx", W_LDX);
    start = 1'b0;
    step("mrst_ldy", W_LDY);
    step("mrst_acc1", W_ACC);
    step("mrst_acc2", W_ACC);
    RST = 1'b1;
    step("mrst_idle", W_IDLE);
    RST = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (ctl != W_IDLE) done_seen++;
    end
    check("mrst_stays_idle", 32'(done_seen), 32'd0);

`ifdef DONE_ACK_EN
    // OUT held while done_ack is low, released on the acknowledge edge
    a = 6'd5; b = 6'd7; n_iter = 4'd0; done_ack = 1'b0; start = 1'b1;
    step("ack_ldx", W_LDX);
    start = 1'b0;
    step("ack_ldy", W_LDY);
    step("ack_out1", W_OUT);
    step("ack_out2", W_OUT);
    step("ack_out3", W_OUT);
    check("ack_result", 32'(sum), 32'd15);
    done_ack = 1'b1;
    step("ack_idle", W_IDLE);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
